// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences one pipeline load/store at a time onto a simple word-wide memory
// responder. Requests are checked for alignment. Store data is replicated
// across the byte lanes with matching strobes. Load data is lane-selected and
// zero- or sign-extended. A bounded wait on mem_dready turns a stuck
// responder into an error response instead of a hang.
//
// Timing seen from the pipeline, with the accept edge taken as edge 0:
//   - aligned access: mem_re/mem_we are high from cycle 1 until the edge where
//     mem_dready is sampled high (edge k). The block sits in RESP during
//     cycle k+1, and resp_valid pulses in cycle k+2.
//   - misaligned access: RESP during cycle 1, and resp_valid pulses in cycle 2.
// Every memory-side and response output comes straight from a flop. The
// response pulse is therefore launched by the RESP state, and it is visible
// in the cycle after RESP.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only while idle and no response
// pulse is showing, so at most one request is ever outstanding. The next
// request can transfer no earlier than the edge that ends the cycle after the
// resp_valid pulse. resp_valid has no back-pressure: it is a one-cycle
// strobe, and resp_err/resp_rdata are meaningful only while it is high.
//
// dbg_state exposes the FSM encoding (0 IDLE, 1 READ, 2 WRITE, 3 RESP).

module mem_access_ctrl #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    // pipeline request side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    // pipeline response side
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    // memory responder side
    output logic              mem_re,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    input  logic              mem_dready,
    // debug
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Request fields latched on accept. The address and store data live
    // directly in mem_addr/mem_din.
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;

    // Outcome of the access, held in RESP until it is launched onto resp_*.
    logic        err_q;
    logic [31:0] rdata_q;

    // Cycles spent in READ/WRITE with mem_dready low.
    logic [3:0]  wait_cnt;

    // Next-state values for every registered output and datapath flop.
    logic              req_ready_d;
    logic              resp_valid_d;
    logic              resp_err_d;
    logic [31:0]       resp_rdata_d;
    logic              mem_re_d;
    logic [3:0]        mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [31:0]       mem_din_d;
    logic [1:0]        size_d;
    logic              signed_d;
    logic [1:0]        off_d;
    logic              err_d;
    logic [31:0]       rdata_d;
    logic [3:0]        wait_cnt_d;

    // Decoded helpers.
    logic        accept;
    logic [1:0]  req_off;
    logic        misaligned;
    logic        timeout_hit;
    logic [3:0]  store_strobe;
    logic [31:0] store_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;

    assign req_off   = req_addr[1:0];
    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

    // timeout_hit is true in the cycle that would be the TIMEOUT-th cycle
    // without mem_dready. A mem_dready sampled in that same cycle still takes
    // priority in the output logic.
    assign timeout_hit = (wait_cnt == 4'(TIMEOUT - 1));

    // Alignment check: bytes are always legal, halves need an even offset,
    // and words (size 2 or 3) need offset 0.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_off[0];
            default: misaligned = (req_off != 2'd0);
        endcase
    end

    // Store path: shift the lane strobes to the offset and replicate the
    // data, so the memory can take the enabled lanes from their natural
    // position.
    always_comb begin
        store_strobe = 4'b1111;
        store_data   = req_wdata;
        case (req_size)
            2'd0: begin
                store_strobe = 4'b0001 << req_off;
                store_data   = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                store_strobe = 4'b0011 << req_off;
                store_data   = {2{req_wdata[15:0]}};
            end
            default: begin
                store_strobe = 4'b1111;
                store_data   = req_wdata;
            end
        endcase
    end

    // Load path: pick the addressed lane out of the returned word, then
    // zero- or sign-extend it.
    always_comb begin
        lane_b    = 8'd0;
        lane_h    = 16'd0;
        load_data = 32'd0;
        case (off_q)
            2'd0:    lane_b = mem_dout[7:0];
            2'd1:    lane_b = mem_dout[15:8];
            2'd2:    lane_b = mem_dout[23:16];
            default: lane_b = mem_dout[31:24];
        endcase
        // Halves are always at offset 0 or 2 once they get this far.
        lane_h = off_q[1] ? mem_dout[31:16] : mem_dout[15:0];
        case (size_q)
            2'd0:    load_data = {{24{signed_q & lane_b[7]}}, lane_b};
            2'd1:    load_data = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_data = mem_dout;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic. mem_dready is looked at only in READ/WRITE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        next_state = RESP;
                    end else if (req_we) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ, WRITE: begin
                if (mem_dready || timeout_hit) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM output logic: next values for the registered outputs and the
    // latched request and outcome. Memory strobes hold their value unless
    // they are explicitly changed.
    always_comb begin
        req_ready_d  = req_ready;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        mem_re_d     = mem_re;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_din_d    = mem_din;
        size_d       = size_q;
        signed_d     = signed_q;
        off_d        = off_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        wait_cnt_d   = wait_cnt;
        case (state)
            IDLE: begin
                // While the response pulse is showing (first IDLE cycle),
                // req_ready is still low, so nothing can be accepted then.
                // After that cycle, req_ready rises.
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    size_d      = req_size;
                    signed_d    = req_signed;
                    off_d       = req_off;
                    wait_cnt_d  = 4'd0;
                    err_d       = misaligned;
                    rdata_d     = 32'd0;
                    if (!misaligned) begin
                        mem_addr_d = req_addr[ADDR_W+1:2];
                        if (req_we) begin
                            mem_we_d  = store_strobe;
                            mem_din_d = store_data;
                        end else begin
                            mem_re_d  = 1'b1;
                        end
                    end
                end
            end
            READ, WRITE: begin
                if (mem_dready) begin
                    mem_re_d = 1'b0;
                    mem_we_d = 4'd0;
                    err_d    = 1'b0;
                    rdata_d  = (state == READ) ? load_data : 32'd0;
                end else if (timeout_hit) begin
                    mem_re_d = 1'b0;
                    mem_we_d = 4'd0;
                    err_d    = 1'b1;
                    rdata_d  = 32'd0;
                end else begin
                    wait_cnt_d = wait_cnt + 4'd1;
                end
            end
            RESP: begin
                req_ready_d  = 1'b0;
                resp_valid_d = 1'b1;
                resp_err_d   = err_q;
                resp_rdata_d = rdata_q;
            end
            default: begin
                req_ready_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers. Reset forces everything idle at once,
    // even in the middle of an access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_re     <= 1'b0;
            mem_we     <= 4'd0;
            mem_addr   <= '0;
            mem_din    <= 32'd0;
            size_q     <= 2'd0;
            signed_q   <= 1'b0;
            off_q      <= 2'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            wait_cnt   <= 4'd0;
        end else begin
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_re     <= mem_re_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_din    <= mem_din_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            off_q      <= off_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            wait_cnt   <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a table of load/store vectors is played through
// a bench-driven memory responder. The bench checks the memory-side strobes
// every cycle. A queue of expected responses is filled when each request is
// driven, and it is drained when resp_valid appears. Hand-written sequences
// cover reset and restart in the middle of an access.

module tb_mem_access_ctrl;

    localparam int AW = 7;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT signals
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_re;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;
    logic          mem_dready;
    logic [1:0]    dbg_state;

    mem_access_ctrl #(.ADDR_W(AW), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_dready (mem_dready),
        .dbg_state  (dbg_state)
    );

    // counters and scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];   // {resp_err, resp_rdata}

    // delay: number of mem_re/mem_we cycles before mem_dready; -1 = never.
    // exp_lat: cycle (after the accept edge) in which resp_valid pulses.
    typedef struct {
        logic          we;
        logic [1:0]    size;
        logic          sgn;
        logic [AW+1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   dout;
        int            delay;
        logic          exp_err;
        logic [31:0]   exp_rdata;
        logic [3:0]    exp_mem_we;
        logic [31:0]   exp_din;
        logic [AW-1:0] exp_maddr;
        int            exp_lat;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_junk_req();
        req_valid  = 1'b1;
        req_we     = 1'($urandom_range(0, 1));
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = 9'($urandom_range(0, 511));
        req_wdata  = $urandom;
    endtask

    // Entered at a falling edge with the DUT idle and ready; leaves at the
    // falling edge of the cycle after the response pulse.
    task automatic run_vec(input vec_t v, input int idx);
        logic        acc;
        logic        exp_re;
        logic [32:0] e;
        acc    = (v.exp_lat != 2);
        exp_re = acc && !v.we;
        check($sformatf("v%0d_ready_pre", idx), 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        mem_dready = 1'b0;
        mem_dout   = $urandom;
        exp_q.push_back({v.exp_err, v.exp_rdata});
        @(posedge clk);
        for (int j = 1; j <= v.exp_lat + 1; j++) begin
            @(negedge clk);
            check($sformatf("v%0d_c%0d_resp_valid", idx, j), 32'(resp_valid), 32'(j == v.exp_lat));
            check($sformatf("v%0d_c%0d_req_ready", idx, j), 32'(req_ready), 32'(j == v.exp_lat + 1));
            if (acc && j <= v.exp_lat - 2) begin
                check($sformatf("v%0d_c%0d_mem_re", idx, j), 32'(mem_re), 32'(exp_re));
                check($sformatf("v%0d_c%0d_mem_we", idx, j), 32'(mem_we), 32'(v.exp_mem_we));
                check($sformatf("v%0d_c%0d_mem_addr", idx, j), 32'(mem_addr), 32'(v.exp_maddr));
                if (v.we) begin
                    check($sformatf("v%0d_c%0d_mem_din", idx, j), mem_din, v.exp_din);
                end
            end else begin
                check($sformatf("v%0d_c%0d_mem_re_idle", idx, j), 32'(mem_re), 32'd0);
                check($sformatf("v%0d_c%0d_mem_we_idle", idx, j), 32'(mem_we), 32'd0);
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("v%0d_resp_extra", idx), 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("v%0d_resp_err", idx), 32'(resp_err), 32'(e[32]));
                    check($sformatf("v%0d_resp_rdata", idx), resp_rdata, e[31:0]);
                end
            end
            // responder for this cycle; dready in RESP/IDLE must be ignored
            mem_dready = 1'b0;
            mem_dout   = $urandom;
            if (acc && v.delay >= 0 && j == v.delay + 1) begin
                mem_dready = 1'b1;
                mem_dout   = v.dout;
            end
            if (j >= v.exp_lat - 1) begin
                mem_dready = 1'b1;
            end
            // requests while busy must be ignored
            if (j < v.exp_lat) begin
                drive_junk_req();
            end else begin
                req_valid = 1'b0;
            end
        end
        check($sformatf("v%0d_resp_missing", idx), 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        mem_dready = 1'b0;
    endtask

    initial begin
        //            we    sz    sg    addr     wdata          dout           dly  err   rdata          mwe      din            maddr    lat
        vecs[0]  = '{1'b0, 2'd2, 1'b0, 9'h014, 32'h0,         32'h89ABCDEF,  3,   1'b0, 32'h89ABCDEF,  4'b0000, 32'h0,         7'h05,   6};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 9'h007, 32'h0,         32'h80FF0011,  0,   1'b0, 32'hFFFFFF80,  4'b0000, 32'h0,         7'h01,   3};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 9'h007, 32'h0,         32'h80FF0011,  0,   1'b0, 32'h00000080,  4'b0000, 32'h0,         7'h01,   3};
        vecs[3]  = '{1'b1, 2'd1, 1'b0, 9'h00A, 32'h1234BEEF,  32'h0,         2,   1'b0, 32'h0,         4'b1100, 32'hBEEFBEEF,  7'h02,   5};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 9'h003, 32'h0,         32'h0,         0,   1'b1, 32'h0,         4'b0000, 32'h0,         7'h00,   2};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 9'h006, 32'h0,         32'h80FF0011,  1,   1'b0, 32'hFFFF80FF,  4'b0000, 32'h0,         7'h01,   4};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 9'h004, 32'h0,         32'h1234F00D,  0,   1'b0, 32'h0000F00D,  4'b0000, 32'h0,         7'h01,   3};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 9'h1FD, 32'hAABBCC5A,  32'h0,         0,   1'b0, 32'h0,         4'b0010, 32'h5A5A5A5A,  7'h7F,   3};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 9'h020, 32'hDEADBEEF,  32'h0,         1,   1'b0, 32'h0,         4'b1111, 32'hDEADBEEF,  7'h08,   4};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 9'h001, 32'h12345678,  32'h0,         0,   1'b1, 32'h0,         4'b0000, 32'h0,         7'h00,   2};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 9'h001, 32'h0,         32'h00007F00,  0,   1'b0, 32'h0000007F,  4'b0000, 32'h0,         7'h00,   3};
        vecs[11] = '{1'b0, 2'd3, 1'b0, 9'h00C, 32'h0,         32'h01020304,  2,   1'b0, 32'h01020304,  4'b0000, 32'h0,         7'h03,   5};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 9'h00E, 32'h0,         32'h0,         0,   1'b1, 32'h0,         4'b0000, 32'h0,         7'h00,   2};
        vecs[13] = '{1'b0, 2'd1, 1'b1, 9'h002, 32'h0,         32'h7FFF8000,  0,   1'b0, 32'h00007FFF,  4'b0000, 32'h0,         7'h00,   3};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 9'h010, 32'h0,         32'h0,         -1,  1'b1, 32'h0,         4'b0000, 32'h0,         7'h04,   17};
        vecs[15] = '{1'b0, 2'd2, 1'b0, 9'h010, 32'h0,         32'hCAFEF00D,  14,  1'b0, 32'hCAFEF00D,  4'b0000, 32'h0,         7'h04,   17};
        vecs[16] = '{1'b1, 2'd0, 1'b0, 9'h003, 32'h000000C3,  32'h0,         0,   1'b0, 32'h0,         4'b1000, 32'hC3C3C3C3,  7'h00,   3};

        // reset phase
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = 32'd0;
        mem_dout   = 32'd0;
        mem_dready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_re",     32'(mem_re),     32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_din",    mem_din,         32'd0);
        check("rst_resp_rdata", resp_rdata,      32'd0);
        check("rst_state",      32'(dbg_state),  32'd0);
        rst = 1'b1;
        @(negedge clk);

        // table-driven vectors, back to back
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // reset in the middle of a load, with a new request pending
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 9'h024;
        req_wdata  = 32'd0;
        mem_dready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_mem_re_before", 32'(mem_re),   32'd1);
        check("mid_mem_addr",      32'(mem_addr), 32'd9);
        check("mid_req_ready",     32'(req_ready), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_mem_re",     32'(mem_re),     32'd0);
        check("mid_rst_mem_addr",   32'(mem_addr),   32'd0);
        check("mid_rst_req_ready",  32'(req_ready),  32'd1);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_state",      32'(dbg_state),  32'd0);
        @(negedge clk);
        check("mid_rst_held_mem_re", 32'(mem_re), 32'd0);
        check("mid_rst_held_state",  32'(dbg_state), 32'd0);
        req_valid = 1'b0;
        rst = 1'b1;

        // clean restart after reset release
        run_vec(vecs[0], 100);
        run_vec(vecs[3], 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, memory word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles to wait for mem_dready before aborting.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  pipeline load/store request.
REQ-006 SHALL have port req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
REQ-007 SHALL have port req_we  input  1  1=store, 0=load.
REQ-008 SHALL have port req_size  input  2  0=byte, 1=half, 2=word; 3 is treated as word.
REQ-009 SHALL have port req_signed  input  1  sign-extend load result.
REQ-010 SHALL have port req_addr  input  ADDR_W+2  byte address; [1:0]=lane offset, [ADDR_W+1:2]=word address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_err  output  1  valid with resp_valid; misalignment or timeout.
REQ-014 SHALL have port resp_rdata  output  32  aligned and extended load data; 0 for stores and errors.
REQ-015 SHALL have port mem_re  output  1  read enable to memory responder.
REQ-016 SHALL have port mem_we  output  4  byte-lane write strobes; lane 0 = bits 7:0.
REQ-017 SHALL have port mem_addr  output  ADDR_W  word address.
REQ-018 SHALL have port mem_din  output  32  lane-replicated write data.
REQ-019 SHALL have port mem_dout  input  32  read data from the responder.
REQ-020 SHALL have port mem_dready  input  1  responder completion, registered on the responder side.

Function
REQ-021 SHALL implement states IDLE, READ, WRITE, RESP; every memory-side and response output SHALL be registered.
REQ-022 On accept in IDLE, the block SHALL latch all req_* fields and check alignment: a half at odd offset, or a word at nonzero offset, is misaligned.
REQ-023 A misaligned accept SHALL go to RESP with resp_err=1 and SHALL NOT assert mem_re or mem_we.
REQ-024 An aligned load SHALL go to READ with mem_re=1 and mem_addr=req_addr[ADDR_W+1:2] from the next cycle.
REQ-025 An aligned store SHALL go to WRITE with mem_we=0001<<off for a byte, 0011<<off for a half, or 1111 for a word.
REQ-026 For stores, mem_din SHALL be {4{wdata[7:0]}} for a byte, {2{wdata[15:0]}} for a half, or wdata for a word.
REQ-027 mem_re and mem_we SHALL be held stable until mem_dready is sampled high; they SHALL be 0 in the following cycle.
REQ-028 In READ, when mem_dready=1 the block SHALL capture mem_dout, select lane off (byte) or off/2 (half), and zero- or sign-extend per req_signed into resp_rdata.
REQ-029 A 4-bit wait counter SHALL clear on entering READ/WRITE and increment each cycle mem_dready=0.
REQ-030 When the wait counter reaches TIMEOUT, the block SHALL drop mem_re/mem_we and go to RESP with resp_err=1.
REQ-031 If mem_dready and timeout coincide, mem_dready SHALL win and the access SHALL complete without error.
REQ-032 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE.
REQ-033 Latency from accept to resp_valid SHALL be (cycles until mem_dready seen)+2; a misaligned request SHALL complete in 2 cycles.
REQ-034 req_ready SHALL be 0 in READ/WRITE/RESP; req_valid SHALL be ignored there, and a new request SHALL be accepted no earlier than the cycle after resp_valid.
REQ-035 mem_dready SHALL be ignored in IDLE and RESP.

Reset
REQ-036 rst low SHALL immediately (asynchronously) force IDLE, clear the wait counter, and set req_ready=1 and mem_re, mem_we, mem_addr, mem_din, resp_valid, resp_err, resp_rdata to 0, including mid-access; the block SHALL restart cleanly after rst is released.

Verification
REQ-037 Load word addr 0x014, mem_dout=0x89ABCDEF, dready 3 cycles after mem_re -> mem_addr=5, resp_rdata=0x89ABCDEF, resp_err=0, single pulse.
REQ-038 Signed load byte addr 0x007 with mem_dout=0x80FF0011 -> resp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-039 Store half addr 0x00A, wdata=0x1234BEEF -> mem_we=1100, mem_din=0xBEEFBEEF, mem_addr=2, held until dready.
REQ-040 Load word addr 0x003 -> no mem_re, resp_valid with resp_err=1 two cycles after accept.
REQ-041 Load with mem_dready stuck at 0 -> mem_re drops and resp_err=1 after TIMEOUT=15 wait cycles; a coincident dready on cycle 15 completes without error.
REQ-042 rst asserted during READ with req_valid high -> outputs 0 immediately; after release, the next request is accepted and completes normally.
